cr_trap_seq: RTL and testbench
==============================

CR_TRAP_SEQ -- requirements
Module: cr_trap_seq

Interface
REQ-001 SHALL have port clock, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port hold, input, 1 bit: pipeline stall; freezes the sequencer state and drain counter.
REQ-004 SHALL have port trapReq, input, 1 bit: exception-entry request, level, held until trapAck.
REQ-005 SHALL have port trapCode, input, 16 bits: exception code.
REQ-006 SHALL have port trapAddr, input, 64 bits: faulting address, destined for TEA.
REQ-007 SHALL have port rteReq, input, 1 bit: return-from-exception request, level, held until rteAck.
REQ-008 SHALL have ports curPc (input, 48 bits), curSr (input, 64 bits), curSp (input, 48 bits), curSpc (input, 48 bits), curExsr (input, 64 bits), curSsp (input, 48 bits), curVbr (input, 48 bits): live control/GPR values.
REQ-009 SHALL have ports trapAck and rteAck, output, 1 bit each: one-cycle completion pulses.
REQ-010 SHALL have port seqFlush, output, 1 bit: flush EX1-EX3.
REQ-011 SHALL have port seqBusy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port crWrEn, output, 1 bit: one-cycle commit strobe for all cr* outputs.
REQ-013 SHALL have ports crPc (48 bits), crSr (64 bits), crSpc (48 bits), crExsr (64 bits), crTea (64 bits), crSsp (48 bits), all outputs: values committed when crWrEn=1.
REQ-014 SHALL have ports spWrEn (output, 1 bit) and spVal (output, 48 bits): stack-pointer swap write.

Function
REQ-015 States SHALL be IDLE, DRAIN, COMMIT; a mode flag (0=trap, 1=rte) SHALL be latched on leaving IDLE.
REQ-016 In IDLE with hold=0: trapReq=1 SHALL enter DRAIN with mode=0, else rteReq=1 SHALL enter DRAIN with mode=1; trap wins when both are asserted.
REQ-017 On leaving IDLE, trapCode, trapAddr, curPc and curSr SHALL be latched internally.
REQ-018 DRAIN SHALL assert seqFlush and last exactly 3 non-hold cycles; hold=1 SHALL freeze the counter while seqFlush stays asserted.
REQ-019 COMMIT (hold=0) SHALL assert crWrEn for one cycle, pulse trapAck (mode 0) or rteAck (mode 1), and return to IDLE; with hold=1 it SHALL wait, with no outputs pulsed.
REQ-020 Latency SHALL be: request sampled in cycle N, commit in cycle N+4 when no hold is applied.
REQ-021 Trap commit: crSpc=latched PC; crExsr={16'h0, latched SR[31:0], latched code}; crTea=latched addr.
REQ-022 Trap commit: crSr=latched SR with bits 30, 29 and 28 set.
REQ-023 Trap commit: crPc=curVbr+{latched code[15:12],3'b000}, modulo 2^48.
REQ-024 Trap commit, latched SR[30]=0: spWrEn=1, spVal=curSsp, crSsp=curSp; otherwise spWrEn=0 and crSsp=curSsp.
REQ-025 Trap commit, latched SR[29]=1 (double fault): crPc SHALL equal curVbr (offset 0), crExsr[15:0]=16'hFFFF, with all other fields per REQ-021/022.
REQ-026 RTE commit: crPc=curSpc; crSr={latched SR[63:32], curExsr[47:16]}; crSpc=curSpc, crExsr=curExsr, crTea=trapAddr latched value unchanged from its last trap.
REQ-027 RTE commit, restored SR[30]=0: spWrEn=1, spVal=curSsp, crSsp=curSp; otherwise spWrEn=0.
REQ-028 Requests asserted while seqBusy=1 SHALL be ignored until IDLE; the requester deasserts in the ack cycle.
REQ-029 Outside COMMIT, crWrEn, spWrEn, trapAck and rteAck SHALL be 0; the cr* data outputs hold their last values.

Reset
REQ-030 reset=0 SHALL, asynchronously, force IDLE, clear the drain counter and mode, and drive every output to 0.
REQ-031 reset asserted mid-DRAIN or mid-COMMIT SHALL abort the sequence with no crWrEn or ack pulse.
REQ-032 After reset deassertion, the first request SHALL be sampled on the first rising edge with reset=1.

Verification
REQ-033 Trap from user: curSr=0, curPc=0x1000, curVbr=0x8000, code=0x3005, curSp=0x2000, curSsp=0x9000 -> cycle N+4: crPc=0x8018, crSpc=0x1000, crSr=0x70000000, crExsr=0x3005, spVal=0x9000, crSsp=0x2000, trapAck=1.
REQ-034 Simultaneous trapReq and rteReq -> trap sequence; rteReq still high at IDLE is serviced next, with commit 5 cycles after trapAck.
REQ-035 RTE: curExsr=0x0000_0000_0000_3005, curSpc=0x1000 -> crPc=0x1000, crSr[31:0]=0, spWrEn=1, rteAck=1.
REQ-036 Hold=1 for 2 cycles during DRAIN -> commit at N+6, with seqFlush high throughout.
REQ-037 Double fault: curSr=0x20000000 and code=0x4001 -> crPc=curVbr and crExsr[15:0]=0xFFFF.
REQ-038 Reset pulse at N+2 of a trap -> no crWrEn or trapAck, outputs 0, state IDLE.

Source files
------------

// File: rtl/cr_trap_seq.sv
// rtl/cr_trap_seq.sv - exception entry / return sequencer committing control registers
module cr_trap_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        trapReq,
    input  logic [15:0] trapCode,
    input  logic [63:0] trapAddr,
    input  logic        rteReq,
    input  logic [47:0] curPc,
    input  logic [63:0] curSr,
    input  logic [47:0] curSp,
    input  logic [47:0] curSpc,
    input  logic [63:0] curExsr,
    input  logic [47:0] curSsp,
    input  logic [47:0] curVbr,
    output logic        trapAck,
    output logic        rteAck,
    output logic        seqFlush,
    output logic        seqBusy,
    output logic        crWrEn,
    output logic [47:0] crPc,
    output logic [63:0] crSr,
    output logic [47:0] crSpc,
    output logic [63:0] crExsr,
    output logic [63:0] crTea,
    output logic [47:0] crSsp,
    output logic        spWrEn,
    output logic [47:0] spVal
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [15:0] code_q, code_d;
    logic [47:0] pc_q, pc_d;
    logic [63:0] sr_q, sr_d;
    logic [63:0] tea_q, tea_d;
    logic        fire;

    // Last committed values; the cr* outputs show these outside a commit.
    logic [47:0] out_pc_q;
    logic [63:0] out_sr_q;
    logic [47:0] out_spc_q;
    logic [63:0] out_exsr_q;
    logic [63:0] out_tea_q;
    logic [47:0] out_ssp_q;
    logic [47:0] out_spval_q;

    logic [47:0] new_pc;
    logic [63:0] new_sr;
    logic [47:0] new_spc;
    logic [63:0] new_exsr;
    logic [47:0] new_ssp;
    logic        sp_swap;
    logic        dbl_fault;
    logic [47:0] vec_off;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        code_d  = code_q;
        pc_d    = pc_q;
        sr_d    = sr_q;
        tea_d   = tea_q;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!hold && (trapReq || rteReq)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 2'd0;
                    mode_d  = !trapReq;
                    code_d  = trapCode;
                    pc_d    = curPc;
                    sr_d    = curSr;
                    // TEA keeps the faulting address of the last trap across an RTE.
                    if (trapReq) begin
                        tea_d = trapAddr;
                    end
                end
            end
            ST_DRAIN: begin
                if (!hold) begin
                    if (cnt_q == 2'd2) begin
                        state_d = ST_COMMIT;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_COMMIT: begin
                if (!hold) begin
                    fire    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        dbl_fault = sr_q[29];
        vec_off   = {41'd0, code_q[15:12], 3'b000};
        new_pc    = curSpc;
        new_sr    = {sr_q[63:32], curExsr[47:16]};
        new_spc   = curSpc;
        new_exsr  = curExsr;
        sp_swap   = !curExsr[46];
        if (!mode_q) begin
            new_pc   = dbl_fault ? curVbr : (curVbr + vec_off);
            new_sr   = sr_q | 64'h0000_0000_7000_0000;
            new_spc  = pc_q;
            new_exsr = {16'h0000, sr_q[31:0], (dbl_fault ? 16'hFFFF : code_q)};
            sp_swap  = !sr_q[30];
        end
        new_ssp = sp_swap ? curSp : curSsp;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            mode_q      <= 1'b0;
            code_q      <= '0;
            pc_q        <= '0;
            sr_q        <= '0;
            tea_q       <= '0;
            out_pc_q    <= '0;
            out_sr_q    <= '0;
            out_spc_q   <= '0;
            out_exsr_q  <= '0;
            out_tea_q   <= '0;
            out_ssp_q   <= '0;
            out_spval_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            sr_q    <= sr_d;
            tea_q   <= tea_d;
            if (fire) begin
                out_pc_q    <= new_pc;
                out_sr_q    <= new_sr;
                out_spc_q   <= new_spc;
                out_exsr_q  <= new_exsr;
                out_tea_q   <= tea_q;
                out_ssp_q   <= new_ssp;
                out_spval_q <= curSsp;
            end
        end
    end

    assign seqBusy  = (state_q != ST_IDLE);
    assign seqFlush = (state_q == ST_DRAIN);
    assign crWrEn   = fire;
    assign trapAck  = fire && !mode_q;
    assign rteAck   = fire && mode_q;
    assign spWrEn   = fire && sp_swap;

    assign crPc   = fire ? new_pc   : out_pc_q;
    assign crSr   = fire ? new_sr   : out_sr_q;
    assign crSpc  = fire ? new_spc  : out_spc_q;
    assign crExsr = fire ? new_exsr : out_exsr_q;
    assign crTea  = fire ? tea_q    : out_tea_q;
    assign crSsp  = fire ? new_ssp  : out_ssp_q;
    assign spVal  = fire ? curSsp   : out_spval_q;

endmodule

// File: tb/tb_cr_trap_seq.sv
// tb/tb_cr_trap_seq.sv - self-checking bench for cr_trap_seq
module tb_cr_trap_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic        trapReq = 1'b0;
    logic        rteReq = 1'b0;
    logic [15:0] trapCode = '0;
    logic [63:0] trapAddr = '0;
    logic [47:0] curPc = '0;
    logic [63:0] curSr = '0;
    logic [47:0] curSp = '0;
    logic [47:0] curSpc = '0;
    logic [63:0] curExsr = '0;
    logic [47:0] curSsp = '0;
    logic [47:0] curVbr = '0;
    logic        trapAck, rteAck, seqFlush, seqBusy, crWrEn, spWrEn;
    logic [47:0] crPc, crSpc, crSsp, spVal;
    logic [63:0] crSr, crExsr, crTea;

    cr_trap_seq dut (
        .clock(clock), .reset(reset), .hold(hold),
        .trapReq(trapReq), .trapCode(trapCode), .trapAddr(trapAddr), .rteReq(rteReq),
        .curPc(curPc), .curSr(curSr), .curSp(curSp), .curSpc(curSpc),
        .curExsr(curExsr), .curSsp(curSsp), .curVbr(curVbr),
        .trapAck(trapAck), .rteAck(rteAck), .seqFlush(seqFlush), .seqBusy(seqBusy),
        .crWrEn(crWrEn), .crPc(crPc), .crSr(crSr), .crSpc(crSpc), .crExsr(crExsr),
        .crTea(crTea), .crSsp(crSsp), .spWrEn(spWrEn), .spVal(spVal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_rte;
        logic [15:0] code;
        logic [63:0] addr;
        logic [47:0] pc;
        logic [63:0] sr;
        logic [47:0] sp;
        logic [47:0] spc;
        logic [63:0] exsr;
        logic [47:0] ssp;
        logic [47:0] vbr;
        logic [47:0] e_pc;
        logic [63:0] e_sr;
        logic [47:0] e_spc;
        logic [63:0] e_exsr;
        logic [63:0] e_tea;
        logic        e_spwr;
        logic [47:0] e_ssp;
    } vec_t;

    vec_t        tbl[6];
    int          total = 0;
    int          bad = 0;
    logic [63:0] last_tea = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected commit computed directly from the architectural rules.
    function automatic vec_t model(input vec_t v, input logic [63:0] tea_prev);
        vec_t r;
        longint unsigned t;
        r = v;
        if (!v.is_rte) begin
            t        = 64'(v.vbr) + 64'(v.code >> 12) * 64'd8;
            r.e_pc   = v.sr[29] ? v.vbr : t[47:0];
            r.e_sr   = v.sr | (64'd7 << 28);
            r.e_spc  = v.pc;
            r.e_exsr = ((v.sr & 64'hFFFF_FFFF) << 16) | 64'(v.sr[29] ? 16'hFFFF : v.code);
            r.e_tea  = v.addr;
            r.e_spwr = (((v.sr >> 30) & 64'd1) == 64'd0);
        end else begin
            r.e_pc   = v.spc;
            r.e_sr   = (v.sr & 64'hFFFF_FFFF_0000_0000) | ((v.exsr >> 16) & 64'hFFFF_FFFF);
            r.e_spc  = v.spc;
            r.e_exsr = v.exsr;
            r.e_tea  = tea_prev;
            r.e_spwr = (r.e_sr[30] == 1'b0);
        end
        r.e_ssp = r.e_spwr ? v.sp : v.ssp;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        trapCode = v.code;
        trapAddr = v.addr;
        curPc    = v.pc;
        curSr    = v.sr;
        curSp    = v.sp;
        curSpc   = v.spc;
        curExsr  = v.exsr;
        curSsp   = v.ssp;
        curVbr   = v.vbr;
    endtask

    task automatic run_seq(input vec_t v, input int hold_at, input int hold_len);
        int edges = 0;
        int flush_n = 0;
        int early = 0;
        bit seen = 1'b0;
        hold = 1'b0;
        drive(v);
        trapReq = !v.is_rte;
        rteReq  = v.is_rte;
        while (!seen && edges < 30) begin
            @(posedge clock);
            edges++;
            #1 hold = (hold_len > 0 && edges >= hold_at && edges < hold_at + hold_len);
            #1;
            if (seqFlush) flush_n++;
            if (crWrEn) seen = 1'b1;
            else if (trapAck || rteAck || spWrEn) early++;
        end
        chk("commit_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("latency", 64'(edges), 64'(4 + hold_len));
            chk("flush_cycles", 64'(flush_n), 64'(3 + ((hold_at <= 3) ? hold_len : 0)));
            chk("early_pulse", 64'(early), 64'd0);
            chk("trapAck", 64'(trapAck), 64'(!v.is_rte));
            chk("rteAck", 64'(rteAck), 64'(v.is_rte));
            chk("crPc", 64'(crPc), 64'(v.e_pc));
            chk("crSr", crSr, v.e_sr);
            chk("crSpc", 64'(crSpc), 64'(v.e_spc));
            chk("crExsr", crExsr, v.e_exsr);
            chk("crTea", crTea, v.e_tea);
            chk("crSsp", 64'(crSsp), 64'(v.e_ssp));
            chk("spWrEn", 64'(spWrEn), 64'(v.e_spwr));
            if (v.e_spwr) chk("spVal", 64'(spVal), 64'(v.ssp));
        end
        trapReq = 1'b0;
        rteReq  = 1'b0;
        hold    = 1'b0;
        @(posedge clock);
        #2;
        chk("idle_crWrEn", 64'(crWrEn), 64'd0);
        chk("idle_busy", 64'(seqBusy), 64'd0);
        chk("held_crPc", 64'(crPc), 64'(v.e_pc));
        if (!v.is_rte) last_tea = v.addr;
    endtask

    initial begin
        int edges;
        int pulses;
        bit seen;
        vec_t v;

        tbl[0] = '{1'b0, 16'h3005, 64'hDEAD_BEEF_0000_1234, 48'h1000, 64'h0, 48'h2000, 48'h0, 64'h0,
                   48'h9000, 48'h8000, 48'h8018, 64'h7000_0000, 48'h1000, 64'h3005,
                   64'hDEAD_BEEF_0000_1234, 1'b1, 48'h2000};
        tbl[1] = '{1'b0, 16'hA123, 64'h0000_0000_CAFE_0001, 48'h4444, 64'h0000_0001_4000_00F0, 48'h2000,
                   48'h0, 64'h0, 48'h9000, 48'h10_0000, 48'h10_0050, 64'h0000_0001_7000_00F0, 48'h4444,
                   64'h0000_4000_00F0_A123, 64'h0000_0000_CAFE_0001, 1'b0, 48'h9000};
        tbl[2] = '{1'b0, 16'h4001, 64'h1111_2222_3333_4444, 48'h2222, 64'h2000_0000, 48'h2000, 48'h0,
                   64'h0, 48'h9000, 48'h8000, 48'h8000, 64'h7000_0000, 48'h2222,
                   64'h0000_2000_0000_FFFF, 64'h1111_2222_3333_4444, 1'b1, 48'h2000};
        tbl[3] = '{1'b1, 16'h0, 64'h5555, 48'h0, 64'hABCD_0000_7000_0000, 48'h2000, 48'h1000, 64'h3005,
                   48'h9000, 48'h8000, 48'h1000, 64'hABCD_0000_0000_0000, 48'h1000, 64'h3005,
                   64'h1111_2222_3333_4444, 1'b1, 48'h2000};
        tbl[4] = '{1'b1, 16'h0, 64'h6666, 48'h0, 64'h0, 48'h2000, 48'h7777, 64'h0000_4000_1234_5678,
                   48'h9000, 48'h8000, 48'h7777, 64'h0000_0000_4000_1234, 48'h7777,
                   64'h0000_4000_1234_5678, 64'h1111_2222_3333_4444, 1'b0, 48'h9000};
        tbl[5] = '{1'b0, 16'hF000, 64'h7, 48'hABC, 64'h4000_0000, 48'h2000, 48'h0, 64'h0, 48'h9000,
                   48'hFFFF_FFFF_FFF0, 48'h68, 64'h7000_0000, 48'hABC, 64'h0000_4000_0000_F000,
                   64'h7, 1'b0, 48'h9000};

        repeat (2) @(posedge clock);
        #2;
        chk("rst_busy", 64'(seqBusy), 64'd0);
        chk("rst_flush", 64'(seqFlush), 64'd0);
        chk("rst_crWrEn", 64'(crWrEn), 64'd0);
        chk("rst_crPc", 64'(crPc), 64'd0);
        chk("rst_crTea", crTea, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_seq(tbl[i], 0, 0);
        run_seq(tbl[0], 2, 2);
        run_seq(tbl[5], 4, 1);

        // Trap and RTE requested together: trap first, RTE five cycles after trapAck.
        drive(tbl[0]);
        trapReq = 1'b1;
        rteReq  = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clock);
            edges++;
            #2;
            seen = trapAck;
        end
        chk("both_trap_first", 64'(seen), 64'd1);
        chk("both_trap_lat", 64'(edges), 64'd4);
        chk("both_no_rteAck", 64'(rteAck), 64'd0);
        trapReq = 1'b0;
        last_tea = tbl[0].addr;
        v = tbl[0];
        v.is_rte = 1'b1;
        v = model(v, last_tea);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clock);
            edges++;
            #2;
            seen = rteAck;
        end
        chk("both_rte_served", 64'(seen), 64'd1);
        chk("both_rte_gap", 64'(edges), 64'd5);
        chk("both_rte_crPc", 64'(crPc), 64'(v.e_pc));
        chk("both_rte_crSr", crSr, v.e_sr);
        rteReq = 1'b0;
        @(posedge clock);
        #2;

        for (int i = 0; i < 40; i++) begin
            v.is_rte = 1'($urandom_range(0, 1));
            v.code   = 16'($urandom);
            v.addr   = {$urandom, $urandom};
            v.pc     = 48'({$urandom, $urandom});
            v.sr     = {$urandom, $urandom};
            v.sp     = 48'({$urandom, $urandom});
            v.spc    = 48'({$urandom, $urandom});
            v.exsr   = {$urandom, $urandom};
            v.ssp    = 48'({$urandom, $urandom});
            v.vbr    = 48'({$urandom, $urandom});
            v = model(v, last_tea);
            run_seq(v, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a drain aborts everything.
        drive(tbl[1]);
        trapReq = 1'b1;
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("abort_busy", 64'(seqBusy), 64'd0);
        chk("abort_flush", 64'(seqFlush), 64'd0);
        chk("abort_crPc", 64'(crPc), 64'd0);
        chk("abort_crSr", crSr, 64'd0);
        chk("abort_spVal", 64'(spVal), 64'd0);
        trapReq = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #2;
            if (crWrEn || trapAck || rteAck) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        last_tea = '0;

        v = tbl[4];
        v = model(v, last_tea);
        run_seq(v, 0, 0);
        run_seq(tbl[0], 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
